pcs_tx_ordered_set: RTL and testbench

Parametrised successor to the Clause-36 PCS transmit path. It accepts GMII-style octets (TX_EN_, TX_ER_, TXD_) and emits one 10-bit code-group per clock. It inserts /I/, /S/, /T/, /R/ and /V/ ordered sets with even/odd alignment, error propagation and carrier extension, and tracks running disparity through an 8b/10b encoder. It sits between the GMII source and the serializer.

---
 rtl/pcs_pkg.sv | 31 +++
 rtl/encoder_8b10b.sv | 95 +++++++++
 rtl/pcs_tx_ordered_set.sv | 118 +++++++++++
 tb/tb_pcs_tx_ordered_set.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/pcs_pkg.sv
// Shared constants and types for the 1000BASE-X PCS transmit path.
// Octet values are the 8b/10b source octets; the encoder maps them to code-groups.
package pcs_pkg;

    localparam logic [7:0] K28_5 = 8'hBC;
    localparam logic [7:0] K27_7 = 8'hFB;
    localparam logic [7:0] K29_7 = 8'hFD;
    localparam logic [7:0] K23_7 = 8'hF7;
    localparam logic [7:0] K30_7 = 8'hFE;
    localparam logic [7:0] D5_6  = 8'hC5;
    localparam logic [7:0] D16_2 = 8'h50;

    // Octet that marks a plain carrier-extend cycle; anything else extends as /V/.
    localparam logic [7:0] CE_OCTET = 8'h0F;

    localparam logic RD_NEG = 1'b0;
    localparam logic RD_POS = 1'b1;

    localparam logic [9:0] K28_5_RD_NEG_CG = 10'b0011111010;

    typedef enum logic [2:0] {
        StIdleK,
        StIdleD,
        StStart,
        StData,
        StEopR,
        StExtend,
        StEopR2
    } pcs_state_e;

endpackage

// File: rtl/encoder_8b10b.sv
// Combinational 8b/10b encoder: 5b/6b then 3b/4b sub-blocks, each choosing its
// column from the running disparity in effect at that sub-block.
module encoder_8b10b
    import pcs_pkg::*;
(
    input  logic [7:0] octet,
    input  logic       is_k,
    input  logic       rd_in,
    output logic [9:0] code,
    output logic       rd_out
);

    logic [4:0] x;
    logic [2:0] y;
    logic [5:0] abcdei_n;
    logic [5:0] abcdei;
    logic [3:0] fghj_n;
    logic [3:0] fghj;
    logic       unbal6;
    logic       unbal4;
    logic       rd_mid;
    logic       alt7;

    always_comb begin
        x        = octet[4:0];
        y        = octet[7:5];
        abcdei_n = 6'b000000;
        // Table holds the RD- column; the RD+ column is its complement when unbalanced.
        case (x)
            5'd0:  abcdei_n = 6'b100111;
            5'd1:  abcdei_n = 6'b011101;
            5'd2:  abcdei_n = 6'b101101;
            5'd3:  abcdei_n = 6'b110001;
            5'd4:  abcdei_n = 6'b110101;
            5'd5:  abcdei_n = 6'b101001;
            5'd6:  abcdei_n = 6'b011001;
            5'd7:  abcdei_n = 6'b111000;
            5'd8:  abcdei_n = 6'b111001;
            5'd9:  abcdei_n = 6'b100101;
            5'd10: abcdei_n = 6'b010101;
            5'd11: abcdei_n = 6'b110100;
            5'd12: abcdei_n = 6'b001101;
            5'd13: abcdei_n = 6'b101100;
            5'd14: abcdei_n = 6'b011100;
            5'd15: abcdei_n = 6'b010111;
            5'd16: abcdei_n = 6'b011011;
            5'd17: abcdei_n = 6'b100011;
            5'd18: abcdei_n = 6'b010011;
            5'd19: abcdei_n = 6'b110010;
            5'd20: abcdei_n = 6'b001011;
            5'd21: abcdei_n = 6'b101010;
            5'd22: abcdei_n = 6'b011010;
            5'd23: abcdei_n = 6'b111010;
            5'd24: abcdei_n = 6'b110011;
            5'd25: abcdei_n = 6'b100110;
            5'd26: abcdei_n = 6'b010110;
            5'd27: abcdei_n = 6'b110110;
            5'd28: abcdei_n = is_k ? 6'b001111 : 6'b001110;
            5'd29: abcdei_n = 6'b101110;
            5'd30: abcdei_n = 6'b011110;
            5'd31: abcdei_n = 6'b101011;
            default: abcdei_n = 6'b000000;
        endcase

        unbal6 = ($countones(abcdei_n) != 3);
        // D7 is balanced yet still alternates between 111000 and 000111.
        abcdei = (rd_in && (unbal6 || x == 5'd7)) ? ~abcdei_n : abcdei_n;
        rd_mid = rd_in ^ unbal6;

        // A7 avoids a run of five identical bits across the sub-block boundary.
        alt7 = is_k
            || (!rd_mid && (x == 5'd17 || x == 5'd18 || x == 5'd20))
            || ( rd_mid && (x == 5'd11 || x == 5'd13 || x == 5'd14));

        fghj_n = 4'b0000;
        case (y)
            3'd0: fghj_n = 4'b1011;
            3'd1: fghj_n = is_k ? 4'b0110 : 4'b1001;
            3'd2: fghj_n = is_k ? 4'b1010 : 4'b0101;
            3'd3: fghj_n = 4'b1100;
            3'd4: fghj_n = 4'b1101;
            3'd5: fghj_n = is_k ? 4'b0101 : 4'b1010;
            3'd6: fghj_n = is_k ? 4'b1001 : 4'b0110;
            3'd7: fghj_n = alt7 ? 4'b0111 : 4'b1110;
            default: fghj_n = 4'b0000;
        endcase

        unbal4 = ($countones(fghj_n) != 2);
        // K columns and D.3 swap polarity even when balanced.
        fghj   = (rd_mid && (unbal4 || y == 3'd3 || is_k)) ? ~fghj_n : fghj_n;
        rd_out = rd_mid ^ unbal4;
        code   = {abcdei, fghj};
    end

endmodule

// File: rtl/pcs_tx_ordered_set.sv
// GMII-to-code-group transmit path: frames packets with /S/ /T/ /R/, fills idle
// with /I1/ or /I2/, and propagates errors and carrier extension as /V/ and /R/.
module pcs_tx_ordered_set
    import pcs_pkg::*;
#(
    parameter logic ERR_EN  = 1'b1,
    parameter logic RD_INIT = RD_NEG
) (
    input  logic       clk_,
    input  logic       main_reset_,
    input  logic       TX_EN_,
    input  logic       TX_ER_,
    input  logic [7:0] TXD_,
    output logic [9:0] tx_code_group_,
    output logic       tx_even_,
    output logic       tx_rd_,
    output logic       tx_busy_
);

    pcs_state_e state_q, state_d;
    logic [9:0] code_q, code_d;
    logic       even_q, even_d;
    logic       rd_q, rd_d;
    logic       busy_q, busy_d;
    logic [7:0] enc_octet;
    logic       enc_is_k;
    logic       er_active;

    always_comb begin
        state_d   = state_q;
        enc_octet = K28_5;
        enc_is_k  = 1'b1;
        busy_d    = 1'b1;
        even_d    = ~even_q;
        er_active = ERR_EN & TX_ER_;

        case (state_q)
            StIdleK: begin
                busy_d  = 1'b0;
                state_d = StIdleD;
            end
            StIdleD: begin
                // Choosing the idle data octet by RD leaves idle always ending RD-.
                busy_d    = 1'b0;
                enc_is_k  = 1'b0;
                enc_octet = rd_q ? D16_2 : D5_6;
                state_d   = TX_EN_ ? StStart : StIdleK;
            end
            StStart: begin
                enc_octet = K27_7;
                state_d   = StData;
            end
            StData: begin
                if (!TX_EN_) begin
                    enc_octet = K29_7;
                    state_d   = StEopR;
                end else if (er_active) begin
                    enc_octet = K30_7;
                end else begin
                    enc_is_k  = 1'b0;
                    enc_octet = TXD_;
                end
            end
            StEopR: begin
                enc_octet = K23_7;
                if (er_active) begin
                    state_d = StExtend;
                end else begin
                    state_d = even_d ? StEopR2 : StIdleK;
                end
            end
            StExtend: begin
                enc_octet = (er_active && TXD_ != CE_OCTET) ? K30_7 : K23_7;
                if (!er_active) begin
                    state_d = even_d ? StEopR2 : StIdleK;
                end
            end
            StEopR2: begin
                enc_octet = K23_7;
                state_d   = StIdleK;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = StIdleK;
            end
        endcase
    end

    encoder_8b10b u_encoder (
        .octet  (enc_octet),
        .is_k   (enc_is_k),
        .rd_in  (rd_q),
        .code   (code_d),
        .rd_out (rd_d)
    );

    always_ff @(posedge clk_) begin
        if (main_reset_) begin
            state_q <= StIdleD;
            code_q  <= K28_5_RD_NEG_CG;
            even_q  <= 1'b1;
            rd_q    <= RD_INIT;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            even_q  <= even_d;
            rd_q    <= rd_d;
            busy_q  <= busy_d;
        end
    end

    assign tx_code_group_ = code_q;
    assign tx_even_       = even_q;
    assign tx_rd_         = rd_q;
    assign tx_busy_       = busy_q;

endmodule

// File: tb/tb_pcs_tx_ordered_set.sv
// Scoreboard bench: the driver queues hand-computed code-groups per cycle and a
// separate monitor pops and compares one entry after each rising edge.
module tb_pcs_tx_ordered_set;

    localparam logic [9:0] K285N = 10'b0011111010;
    localparam logic [9:0] K285P = 10'b1100000101;
    localparam logic [9:0] D56   = 10'b1010010110;
    localparam logic [9:0] D162P = 10'b1001000101;
    localparam logic [9:0] SN    = 10'b1101101000;
    localparam logic [9:0] TN    = 10'b1011101000;
    localparam logic [9:0] TP    = 10'b0100010111;
    localparam logic [9:0] RN    = 10'b1110101000;
    localparam logic [9:0] RP    = 10'b0001010111;
    localparam logic [9:0] VN    = 10'b0111101000;
    localparam logic [9:0] VP    = 10'b1000010111;
    localparam logic [9:0] D216N = 10'b1010100110;
    localparam logic [9:0] D270N = 10'b1101100100;
    localparam logic [9:0] D000N = 10'b1001110100;
    localparam logic [9:0] D30N  = 10'b1100011011;

    typedef struct {
        int         step;
        logic       dut;
        logic [9:0] code;
        logic       even;
        logic       rd;
        logic       busy;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic       er  = 1'b0;
    logic [7:0] txd = 8'h00;

    logic [9:0] cg_a, cg_b;
    logic       even_a, even_b, rd_a, rd_b, busy_a, busy_b;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   step_no = 0;
    logic exp_even = 1'b1;

    always #5 clk = ~clk;

    pcs_tx_ordered_set #(
        .ERR_EN  (1'b1),
        .RD_INIT (1'b0)
    ) dut_a (
        .clk_           (clk),
        .main_reset_    (rst),
        .TX_EN_         (en),
        .TX_ER_         (er),
        .TXD_           (txd),
        .tx_code_group_ (cg_a),
        .tx_even_       (even_a),
        .tx_rd_         (rd_a),
        .tx_busy_       (busy_a)
    );

    pcs_tx_ordered_set #(
        .ERR_EN  (1'b0),
        .RD_INIT (1'b1)
    ) dut_b (
        .clk_           (clk),
        .main_reset_    (rst),
        .TX_EN_         (en),
        .TX_ER_         (er),
        .TXD_           (txd),
        .tx_code_group_ (cg_b),
        .tx_even_       (even_b),
        .tx_rd_         (rd_b),
        .tx_busy_       (busy_b)
    );

    // Drive one cycle of inputs and queue the code-group expected after the next edge.
    task automatic s(input logic r, input logic e, input logic x, input logic [7:0] d,
                     input logic which, input logic [9:0] code, input logic rd,
                     input logic busy);
        exp_t ex;
        @(negedge clk);
        rst = r;
        en  = e;
        er  = x;
        txd = d;
        exp_even = r ? 1'b1 : ~exp_even;
        step_no++;
        ex.step = step_no;
        ex.dut  = which;
        ex.code = code;
        ex.even = exp_even;
        ex.rd   = rd;
        ex.busy = busy;
        sb.push_back(ex);
    endtask

    initial begin : monitor
        exp_t       ex;
        logic [12:0] act;
        logic [12:0] want;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                ex   = sb.pop_front();
                act  = ex.dut ? {cg_b, even_b, rd_b, busy_b} : {cg_a, even_a, rd_a, busy_a};
                want = {ex.code, ex.even, ex.rd, ex.busy};
                checks++;
                if (act !== want) begin
                    errors++;
                    $display("FAIL step%0d dut%0d: got cg=%b even=%b rd=%b busy=%b, want cg=%b even=%b rd=%b busy=%b",
                             ex.step, ex.dut, act[12:3], act[2], act[1], act[0],
                             want[12:3], want[2], want[1], want[0]);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no end of stimulus, want end within 200000 time units");
        $fatal(1, "timeout");
    end

    initial begin : driver
        // reset state
        s(1, 0, 0, 8'h00, 0, K285N, 0, 0);
        // idle after reset starts with /I1/ then settles into /I2/
        s(0, 0, 0, 8'h00, 0, D56,   0, 0);
        s(0, 0, 0, 8'h00, 0, K285N, 1, 0);
        s(0, 0, 0, 8'h00, 0, D162P, 0, 0);
        s(0, 0, 0, 8'h00, 0, K285N, 1, 0);
        // TX_EN seen in IDLE_D; /S/ replaces the second octet; /V/ mid-packet; odd /T/
        s(0, 1, 0, 8'h55, 0, D162P, 0, 0);
        s(0, 1, 0, 8'h55, 0, SN,    0, 1);
        s(0, 1, 0, 8'hD5, 0, D216N, 0, 1);
        s(0, 1, 0, 8'h1B, 0, D270N, 0, 1);
        s(0, 1, 1, 8'h12, 0, VN,    0, 1);
        s(0, 1, 0, 8'h00, 0, D000N, 0, 1);
        s(0, 0, 0, 8'h00, 0, TN,    0, 1);
        s(0, 0, 0, 8'h00, 0, RN,    0, 1);
        s(0, 0, 0, 8'h00, 0, RN,    0, 1);
        s(0, 0, 0, 8'h00, 0, K285N, 1, 0);
        // TX_EN (with TX_ER) rising in IDLE_K; RD+ data; even /T/ gives /T/R/ only
        s(0, 0, 0, 8'h00, 0, D162P, 0, 0);
        s(0, 1, 1, 8'h55, 0, K285N, 1, 0);
        s(0, 1, 1, 8'h55, 0, D162P, 0, 0);
        s(0, 1, 0, 8'hD5, 0, SN,    0, 1);
        s(0, 1, 0, 8'h03, 0, D30N,  1, 1);
        s(0, 0, 0, 8'h00, 0, TP,    1, 1);
        s(0, 0, 0, 8'h00, 0, RP,    1, 1);
        s(0, 0, 0, 8'h00, 0, K285P, 0, 0);
        s(0, 0, 0, 8'h00, 0, D56,   0, 0);
        // carrier extension with one /V/ extend cycle, then parity /R/
        s(0, 0, 0, 8'h00, 0, K285N, 1, 0);
        s(0, 1, 0, 8'h55, 0, D162P, 0, 0);
        s(0, 1, 0, 8'h55, 0, SN,    0, 1);
        s(0, 1, 0, 8'h03, 0, D30N,  1, 1);
        s(0, 0, 1, 8'h0F, 0, TP,    1, 1);
        s(0, 0, 1, 8'h0F, 0, RP,    1, 1);
        s(0, 0, 1, 8'h1F, 0, VP,    1, 1);
        s(0, 0, 1, 8'h0F, 0, RP,    1, 1);
        s(0, 0, 0, 8'h00, 0, RP,    1, 1);
        s(0, 0, 0, 8'h00, 0, RP,    1, 1);
        s(0, 0, 0, 8'h00, 0, K285P, 0, 0);
        s(0, 0, 0, 8'h00, 0, D56,   0, 0);
        // reset in DATA: no /T/ flush
        s(0, 0, 0, 8'h00, 0, K285N, 1, 0);
        s(0, 1, 0, 8'h55, 0, D162P, 0, 0);
        s(0, 1, 0, 8'h55, 0, SN,    0, 1);
        s(0, 1, 0, 8'h03, 0, D30N,  1, 1);
        s(1, 1, 0, 8'h03, 0, K285N, 0, 0);
        s(0, 0, 0, 8'h00, 0, D56,   0, 0);
        s(0, 0, 0, 8'h00, 0, K285N, 1, 0);
        // ERR_EN = 0, RD_INIT = 1 instance: TX_ER ignored, plain /T/R/ end
        s(1, 0, 0, 8'h00, 1, K285N, 1, 0);
        s(0, 0, 0, 8'h00, 1, D162P, 0, 0);
        s(0, 0, 0, 8'h00, 1, K285N, 1, 0);
        s(0, 1, 0, 8'h55, 1, D162P, 0, 0);
        s(0, 1, 0, 8'h55, 1, SN,    0, 1);
        s(0, 1, 1, 8'h03, 1, D30N,  1, 1);
        s(0, 0, 1, 8'h0F, 1, TP,    1, 1);
        s(0, 0, 1, 8'h0F, 1, RP,    1, 1);
        s(0, 0, 1, 8'h0F, 1, K285P, 0, 0);
        s(0, 0, 0, 8'h00, 1, D56,   0, 0);

        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending entries, want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
